// File: rtl/mux_arbiter_pkg.sv
// mux_arbiter_pkg
// Types and constants shared by the mux_arbiter slice.
//   arb_state_t      : arbiter FSM state (IDLE / GRANT1 / GRANT2)
//   MAX_HOLD_DEFAULT : default consecutive-grant limit
//   WINNER_REQ1/2    : encoding of the 1-bit last-winner register
//   HOLD_SAT         : saturation value of the 4-bit hold counter
`include "mux_arb_defs.vh"

package mux_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = `MUX_ARB_IDLE,
        GRANT1 = `MUX_ARB_GRANT1,
        GRANT2 = `MUX_ARB_GRANT2
    } arb_state_t;

    localparam int         MAX_HOLD_DEFAULT = `MUX_ARB_MAX_HOLD;
    localparam logic       WINNER_REQ1      = 1'b0;
    localparam logic       WINNER_REQ2      = 1'b1;
    localparam logic [3:0] HOLD_SAT         = 4'd15;

    // Choice made from IDLE: a lone requester wins outright; on a tie the
    // requester that did not win last time goes first.
    function automatic arb_state_t pick_from_idle(input logic r1,
                                                  input logic r2,
                                                  input logic last_winner);
        arb_state_t s;
        s = IDLE;
        if (r1 && r2) begin
            s = (last_winner == WINNER_REQ2) ? GRANT1 : GRANT2;
        end else if (r1) begin
            s = GRANT1;
        end else if (r2) begin
            s = GRANT2;
        end
        return s;
    endfunction

endpackage

// File: rtl/mux.sv
// mux
// Plain 2-bit 2:1 multiplexer.
// Ports:
//   enable : select, 0 = in0, 1 = in1
//   in0    : data input 0
//   in1    : data input 1
//   y      : selected data
module mux (
    input  logic       enable,
    input  logic [1:0] in0,
    input  logic [1:0] in1,
    output logic [1:0] y
);

    assign y = enable ? in1 : in0;

endmodule

// File: rtl/mux_arb_defs.vh
// mux_arb_defs.vh
// Shared constants for the mux_arbiter block: FSM state encodings and the
// default hold limit. Included by mux_arbiter_pkg so that every file that
// imports the package sees one consistent set of values.
`ifndef MUX_ARB_DEFS_VH
`define MUX_ARB_DEFS_VH

`define MUX_ARB_IDLE     2'd0
`define MUX_ARB_GRANT1   2'd1
`define MUX_ARB_GRANT2   2'd2
`define MUX_ARB_MAX_HOLD 4

`endif

// File: rtl/mux_arbiter.sv
// mux_arbiter
// Two-requester arbiter that owns a shared 2-bit output path. A 3-state FSM
// hands the path to one requester at a time, alternating on contention, and
// the granted requester's data is registered onto out one cycle later.
//
// Configuration macro: MUX_ARB_TIMEOUT_EN
//   defined   : a 4-bit hold counter limits a grant to MAX_HOLD cycles
//   undefined : grants last as long as they are requested, no counter
//
// Ports:
//   clk       : clock, rising edge
//   resetn    : synchronous active-low reset
//   req1/req2 : requests from requester 1 / 2
//   in1/in2   : 2-bit data from requester 1 / 2
//   gnt1/gnt2 : requester owns the path this cycle
//   sel       : mux select (0 = in1, 1 = in2), held while idle
//   out       : registered shared data
//   out_valid : out carries data granted in the previous cycle
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req1,
    input  logic       req2,
    input  logic [1:0] in1,
    input  logic [1:0] in2,
    output logic       gnt1,
    output logic       gnt2,
    output logic       sel,
    output logic [1:0] out,
    output logic       out_valid
);

    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
        $error("mux_arbiter: MAX_HOLD must be in 1..15");
    end

    arb_state_t state;
    arb_state_t next_state;
    logic       last_winner;
    logic       sel_hold;
    logic       granted;
    logic       timeout;
    logic [1:0] mux_y;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD - 1);

    logic [3:0] hold_cnt;

    // Hold counter restarts whenever the FSM changes state (so it is 0 in
    // the first cycle of every grant), counts granted cycles and saturates.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold_cnt <= 4'd0;
        end else if (next_state != state) begin
            hold_cnt <= 4'd0;
        end else if (granted && (hold_cnt != HOLD_SAT)) begin
            hold_cnt <= hold_cnt + 4'd1;
        end
    end

    // Raised in the last allowed cycle so the handover happens on the
    // following edge, giving exactly MAX_HOLD granted cycles.
    assign timeout = granted && (hold_cnt == HOLD_LIMIT);
`else
    assign timeout = 1'b0;
`endif

    // Next-state logic. Releasing or timing out hands the path straight to
    // the other requester if it is waiting, otherwise falls back to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                next_state = pick_from_idle(req1, req2, last_winner);
            end
            GRANT1: begin
                if (!req1 || timeout) begin
                    next_state = req2 ? GRANT2 : IDLE;
                end
            end
            GRANT2: begin
                if (!req2 || timeout) begin
                    next_state = req1 ? GRANT1 : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs decode the registered state only; sel follows gnt2 while a
    // grant is active and otherwise keeps whatever it last was.
    always_comb begin
        gnt1    = 1'b0;
        gnt2    = 1'b0;
        sel     = sel_hold;
        granted = 1'b0;
        case (state)
            GRANT1: begin
                gnt1    = 1'b1;
                sel     = 1'b0;
                granted = 1'b1;
            end
            GRANT2: begin
                gnt2    = 1'b1;
                sel     = 1'b1;
                granted = 1'b1;
            end
            default: begin
                gnt1    = 1'b0;
            end
        endcase
    end

    mux u_mux (
        .enable (sel),
        .in0    (in1),
        .in1    (in2),
        .y      (mux_y)
    );

    // State, fairness memory and the registered data path. out_valid is the
    // grant flag one cycle late, matching the cycle in which out is loaded.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            last_winner <= WINNER_REQ2;
            sel_hold    <= 1'b0;
            out         <= 2'b00;
            out_valid   <= 1'b0;
        end else begin
            state     <= next_state;
            sel_hold  <= sel;
            out_valid <= granted;
            if (next_state == GRANT1) begin
                last_winner <= WINNER_REQ1;
            end else if (next_state == GRANT2) begin
                last_winner <= WINNER_REQ2;
            end
            if (granted) begin
                out <= mux_y;
            end
        end
    end

endmodule
